// File: rtl/voting_machine_multi_if.sv
// Ballot-unit bus: keypad/session controls in, counters and result flags out.
// Latency: none, this is plain wiring.
// Backpressure: none; the keypad side drives level controls, the unit answers with registered status.
// Ports: master = keypad/admin side (drives enable, admin_mode, clear_counts, vote);
//        slave  = ballot unit (drives counts, total_votes, winner, tie, pulses, saturated, state_out).
interface voting_machine_multi_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
);
    localparam int IDX_W = $clog2(NUM_CAND);

    logic                      enable;
    logic                      admin_mode;
    logic                      clear_counts;
    logic [NUM_CAND-1:0]       vote;
    logic [NUM_CAND*CNT_W-1:0] counts;
    logic [CNT_W-1:0]          total_votes;
    logic [IDX_W-1:0]          winner;
    logic                      tie;
    logic                      valid_vote;
    logic                      invalid_vote;
    logic                      saturated;
    logic [1:0]                state_out;

    modport master (
        output enable, admin_mode, clear_counts, vote,
        input  counts, total_votes, winner, tie, valid_vote, invalid_vote, saturated, state_out
    );

    modport slave (
        input  enable, admin_mode, clear_counts, vote,
        output counts, total_votes, winner, tie, valid_vote, invalid_vote, saturated, state_out
    );
endinterface

// File: rtl/voting_machine_multi.sv
// Multi-candidate ballot unit: one-hot vote counting with press/release lockout and a registered winner.
// Latency: counters and valid/invalid pulses update on the edge that samples the press; winner on RESULT entry.
// Backpressure: none; presses outside READY, or while a button is still held, are simply not counted.
// Ports: clk, rst (async active-high); bus = voting_machine_multi_if.slave carrying controls and results.
module voting_machine_multi #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    voting_machine_multi_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_CAND);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_READY  = 2'b01,
        S_LOCK   = 2'b10,
        S_RESULT = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_CAND];
    logic [CNT_W-1:0] cnt_d [NUM_CAND];
    logic [CNT_W-1:0] total_q, total_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic             tie_q, tie_d;
    logic             valid_q, valid_d;
    logic             invalid_q, invalid_d;
    logic             sat_q, sat_d;

    // Winner search over the live counters; only captured on IDLE->RESULT.
    logic [CNT_W-1:0] max_val;
    logic [IDX_W-1:0] win_idx;
    logic             win_tie;

    always_comb begin
        max_val = '0;
        win_idx = '0;
        win_tie = 1'b0;
        // Strict '>' keeps the lowest index among equal maxima.
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cnt_q[i] > max_val) begin
                max_val = cnt_q[i];
                win_idx = IDX_W'(i);
            end
        end
        // Any other index at the max is a tie; all-zero counts therefore report a tie on index 0.
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cnt_q[i] == max_val && IDX_W'(i) != win_idx) begin
                win_tie = 1'b1;
            end
        end
    end

    logic vote_onehot;
    assign vote_onehot = (bus.vote != '0) && ((bus.vote & (bus.vote - 1'b1)) == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        winner_d  = winner_q;
        tie_d     = tie_q;
        valid_d   = 1'b0;
        invalid_d = 1'b0;
        sat_d     = sat_q;

        case (state_q)
            S_IDLE: begin
                if (bus.admin_mode) begin
                    state_d  = S_RESULT;
                    winner_d = win_idx;
                    tie_d    = win_tie;
                end else if (bus.clear_counts) begin
                    for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = '0;
                    total_d = '0;
                    sat_d   = 1'b0;
                end else if (bus.enable) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (bus.vote != '0) begin
                    state_d = S_LOCK;
                    if (vote_onehot) begin
                        valid_d = 1'b1;
                        for (int i = 0; i < NUM_CAND; i++) begin
                            if (bus.vote[i]) begin
                                if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
                                // Flag both on reaching all-ones and on further presses at the ceiling.
                                if (cnt_q[i] >= CNT_MAX - CNT_ONE) sat_d = 1'b1;
                            end
                        end
                        if (total_q != CNT_MAX) total_d = total_q + CNT_ONE;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            end
            S_LOCK: begin
                // Wait for full release so a held button cannot be counted twice.
                if (bus.vote == '0) state_d = bus.enable ? S_READY : S_IDLE;
            end
            S_RESULT: begin
                if (!bus.admin_mode) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
            total_q   <= '0;
            winner_q  <= '0;
            tie_q     <= 1'b0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            winner_q  <= winner_d;
            tie_q     <= tie_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
            sat_q     <= sat_d;
        end
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_counts
        assign bus.counts[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign bus.total_votes  = total_q;
    assign bus.winner       = winner_q;
    assign bus.tie          = tie_q;
    assign bus.valid_vote   = valid_q;
    assign bus.invalid_vote = invalid_q;
    assign bus.saturated    = sat_q;
    assign bus.state_out    = state_q;
endmodule
